// File: rtl/criq_port_sched_pkg.sv
// Shared definitions for the rename free-list port scheduler: FSM encoding,
// default geometry and the tag sequence the free-tag queue holds after a clean.
package criq_port_sched_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } criq_state_e;

    localparam int CRIQWIDE_DEF = 5;
    localparam int CRIQDEEP_DEF = 8;

    // Entry i of a freshly cleaned queue holds tag 4*i+2 (2, 6, ..., 30).
    function automatic logic [CRIQWIDE_DEF-1:0] init_tag(input int idx);
        return CRIQWIDE_DEF'(4 * idx + 2);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. The pointer names the lane that wins a tie;
// after any grant it moves to the lane that was not granted.
module rr_arb2 (
    input  logic       Clk,
    input  logic       Rest,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                o_gnt = r_ptr ? 2'b10 : 2'b01;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            r_ptr <= 1'b0;
        end else if (|o_gnt) begin
            r_ptr <= o_gnt[0];
        end
    end

endmodule

// File: rtl/criq_port_sched.sv
// Scheduler for the free-tag queue: arbitrates two allocation and two release
// lanes onto the single pop/push ports, sequences clean/hold and counts free tags.
module criq_port_sched
    import criq_port_sched_pkg::*;
#(
    parameter int CRIQWIDE = CRIQWIDE_DEF,
    parameter int CRIQDEEP = CRIQDEEP_DEF,
    parameter int CNTW     = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic [1:0]          AllocReq,
    output logic [1:0]          AllocGnt,
    output logic [CRIQWIDE-1:0] AllocTag,
    input  logic [1:0]          RelReq,
    input  logic [CRIQWIDE-1:0] RelTag0,
    input  logic [CRIQWIDE-1:0] RelTag1,
    output logic [1:0]          RelGnt,
    input  logic                Flush,
    output logic                QRable,
    input  logic [CRIQWIDE-1:0] QPreOut,
    output logic                QWable,
    output logic [CRIQWIDE-1:0] QDin,
    output logic                QClean,
    input  logic                QFull,
    input  logic                QEmpty,
    output logic [CNTW-1:0]     FreeCount,
    output logic                Busy,
    output logic [1:0]          DbgState
);

    // Handshake: a request is accepted in the cycle its grant bit is high; an
    // ungranted release lane keeps RelReq and its tag stable until granted.
    criq_state_e     r_state;
    criq_state_e     w_state_nxt;
    logic [3:0]      r_hold_cnt;
    logic [CNTW-1:0] r_free_cnt;
    logic            w_clean;
    logic            w_run_ok;

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clean     = 1'b0;
        case (r_state)
            ST_INIT, ST_FLUSH: begin
                w_clean     = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_hold_cnt == 4'(HOLD_CYC - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
            end
        endcase
        // A flush from any state restarts the clean and the hold period.
        if (Flush) begin
            w_state_nxt = ST_FLUSH;
        end
    end

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            r_hold_cnt <= 4'd0;
        end else if (r_state != ST_HOLD) begin
            r_hold_cnt <= 4'd0;
        end else begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
        end
    end

    assign w_run_ok = (r_state == ST_RUN) && !Flush;

    rr_arb2 u_alloc_arb (
        .Clk   (Clk),
        .Rest  (Rest),
        .i_en  (w_run_ok && !QEmpty),
        .i_req (AllocReq),
        .o_gnt (AllocGnt)
    );

    rr_arb2 u_rel_arb (
        .Clk   (Clk),
        .Rest  (Rest),
        .i_en  (w_run_ok && !QFull),
        .i_req (RelReq),
        .o_gnt (RelGnt)
    );

    assign QRable   = |AllocGnt;
    assign AllocTag = QPreOut;
    assign QWable   = |RelGnt;
    assign QDin     = RelGnt[1] ? RelTag1 : RelTag0;
    assign QClean   = w_clean;

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            r_free_cnt <= '0;
        end else if (w_clean) begin
            r_free_cnt <= CNTW'(CRIQDEEP);
        end else if (QWable && !QRable) begin
            r_free_cnt <= r_free_cnt + CNTW'(1);
        end else if (QRable && !QWable) begin
            r_free_cnt <= r_free_cnt - CNTW'(1);
        end
    end

    assign FreeCount = r_free_cnt;
    assign Busy      = (r_state != ST_RUN);
    assign DbgState  = r_state;

endmodule

// File: doc/criq_port_sched.md
Name: criq_port_sched

Overview:
- Scheduler in front of one single-read/single-write free-tag circular queue, the rename free list of 5-bit physical tags.
- Arbitrates two rename-lane allocation requesters and two commit-lane release requesters onto the queue's single read port and single write port.
- Sequences queue initialisation and flush, and tracks the free-tag count.

Parameters:
- CRIQWIDE, 5, tag width.
- CRIQDEEP, 8, number of tags the queue holds after a clean.
- CNTW, 4, FreeCount width; must hold CRIQDEEP.
- HOLD_CYC, 2, grant-blocked cycles after each clean; allowed range 1..15.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rest  in  1  reset, asynchronous, active-high.
- AllocReq  in  2  per-lane tag allocation request.
- AllocGnt  out  2  one-hot-or-zero allocation grant, same cycle as the request.
- AllocTag  out  CRIQWIDE  granted tag; valid while |AllocGnt.
- RelReq  in  2  per-lane tag release request.
- RelTag0  in  CRIQWIDE  tag released by lane 0.
- RelTag1  in  CRIQWIDE  tag released by lane 1.
- RelGnt  out  2  one-hot-or-zero release acceptance.
- Flush  in  1  pipeline flush; restores the queue to its initial contents.
- QRable  out  1  queue read (pop) enable.
- QPreOut  in  CRIQWIDE  queue head, combinational.
- QWable  out  1  queue write (push) enable.
- QDin  out  CRIQWIDE  queue write data.
- QClean  out  1  queue clean pulse.
- QFull  in  1  queue full.
- QEmpty  in  1  queue empty.
- FreeCount  out  CNTW  number of free tags in the queue.
- Busy  out  1  high whenever state != RUN.

Behaviour:
- FSM states: INIT, RUN, FLUSH, HOLD.
- Rest asserted, asynchronously:
  - state=INIT, HoldCnt=0, both round-robin pointers=lane0, FreeCount=0.
  - All grant/enable outputs are combinational and therefore 0 outside RUN.
- INIT: QClean=1 for exactly one cycle, then HOLD.
- FLUSH: QClean=1 for exactly one cycle, then HOLD.
- HOLD: HoldCnt counts 0..HOLD_CYC-1, then RUN. HoldCnt clears on entering HOLD.
- RUN with Flush=1: next state FLUSH, and all grants masked in that same cycle.
- Flush while in INIT/FLUSH/HOLD: re-enter FLUSH, which restarts the hold period.
- Allocation grant (RUN, !Flush, !QEmpty, |AllocReq):
  - Exactly one lane granted. If both request, the rr-pointer lane wins.
  - After a grant the pointer moves to the other lane. No grant means the pointer holds.
  - AllocTag = QPreOut and QRable=1 in the same cycle. Zero extra latency to the requester.
- Release grant (RUN, !Flush, !QFull, |RelReq):
  - One lane accepted, by an independent rr pointer with the same rules.
  - QWable=1. QDin = RelTag of the accepted lane.
- Allocation and release may both be granted in one cycle.
- No bypass: a release never feeds an allocation in the same cycle. An empty queue blocks allocation even if a release is accepted.
- A lane whose RelReq is not granted must hold RelReq and its RelTag stable. The block does not buffer releases.
- Releases presented during Flush/FLUSH/HOLD are not granted. Commit logic re-presents or drops them; the clean restores the tag set.
- FreeCount register:
  - Set to CRIQDEEP on any QClean cycle.
  - Else +1 on QWable only, -1 on QRable only, unchanged on both or neither.
  - Never wraps. Saturation at 0 or CRIQDEEP is prevented by the QEmpty/QFull gating.
- Invariants (bench assertions):
  - FreeCount==0 iff QEmpty.
  - FreeCount==CRIQDEEP iff QFull, checked in RUN.
  - $onehot0(AllocGnt) and $onehot0(RelGnt).
  - QRable==|AllocGnt and QWable==|RelGnt.
- Reset mid-operation: immediate return to INIT. The queue is re-cleaned before any grant.

Decomposition:
- Shared package:
  - FSM state encoding (2-bit INIT=0, RUN=1, FLUSH=2, HOLD=3).
  - CRIQDEEP/CRIQWIDE defaults.
  - Initial tag sequence constants 2,6,...,30 for bench reference.
- One sub-module rr_arb2 (2-request round-robin arbiter with pointer register, Clk/Rest, enable input), instantiated twice, for alloc and release.

Test Plan:
- Reset release, no requests -> QClean=1 on cycle 1; Busy=1 for 1+HOLD_CYC=3 cycles; then RUN with FreeCount=8, QFull=1, Busy=0.
- AllocReq=2'b11 held -> cycle k: AllocGnt=01, AllocTag=2; k+1: AllocGnt=10, AllocTag=6; k+2: AllocGnt=01, AllocTag=10. FreeCount goes 8,7,6,5.
- Alternating single-lane allocs until 8 granted -> QEmpty=1, FreeCount=0, further AllocReq gets AllocGnt=00. Then RelReq=01 with RelTag0=14 -> RelGnt=01, QWable=1, QDin=14; next-cycle alloc returns tag 14.
- FreeCount=3, AllocReq=01, RelReq=11 (RelTag0=6, RelTag1=10) -> same cycle AllocGnt=01 and RelGnt=01, FreeCount stays 3. Next cycle RelGnt=10, QDin=10, FreeCount 4.
- FreeCount=5, assert Flush with AllocReq=11 -> no grants that cycle; next cycle QClean=1; FreeCount=8; grants resume after HOLD_CYC cycles with AllocTag=2.
- Rest pulsed mid-burst (asynchronous, between edges) -> AllocGnt/RelGnt drop immediately; INIT/QClean sequence repeats; rr pointers back to lane0.
